// File: rtl/mod7.sv
// Serial mod-7 reducer: captures an N-bit operand, folds it MSB-first into a 3-bit residue.
// Optional MOD7_LED_EN adds a registered divisible-by-7 indicator on led.
module mod7 (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  configure,
  input  logic [31:0] serial_in,
  output logic [2:0]  out,
  output logic        cnt_out,
  output logic        led
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ACC_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DATA_W-1:0]  shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   width_c;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_nxt_c;
  logic [ACC_W:0]     dbl_c;
  logic               capture_c;
  logic               step_c;
  logic               done_c;

  // Operand width decode
  always_comb begin
    width_c = CNT_W'(32);
    case (configure)
      3'b000:  width_c = CNT_W'(32);
      3'b001:  width_c = CNT_W'(4);
      3'b010:  width_c = CNT_W'(5);
      3'b011:  width_c = CNT_W'(6);
      3'b100:  width_c = CNT_W'(8);
      3'b101:  width_c = CNT_W'(12);
      3'b110:  width_c = CNT_W'(16);
      3'b111:  width_c = CNT_W'(24);
      default: width_c = CNT_W'(32);
    endcase
  end

  // acc*2 + bit is at most 13, so one conditional subtract keeps it in 0..6
  always_comb begin
    dbl_c     = {acc, shreg[DATA_W-1]};
    acc_nxt_c = (dbl_c >= 4'd7) ? ACC_W'(dbl_c - 4'd7) : dbl_c[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture_c = 1'b0;
    step_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          capture_c = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (enable) begin
          step_c = 1'b1;
          if (bit_cnt <= CNT_W'(1)) begin
            done_c    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand is left-aligned on capture so the MSB to consume is always bit 31
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      acc     <= '0;
    end else if (capture_c) begin
      shreg   <= serial_in << (CNT_W'(DATA_W) - width_c);
      bit_cnt <= width_c;
      acc     <= '0;
    end else if (step_c) begin
      shreg   <= {shreg[DATA_W-2:0], 1'b0};
      bit_cnt <= bit_cnt - CNT_W'(1);
      acc     <= acc_nxt_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out     <= '0;
      cnt_out <= 1'b0;
    end else begin
      cnt_out <= done_c;
      if (done_c) out <= acc_nxt_c;
    end
  end

`ifdef MOD7_LED_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      led <= 1'b0;
    else if (done_c) led <= (acc_nxt_c == '0);
  end
`else
  assign led = 1'b0;
`endif

endmodule

// File: tb/tb_mod7.sv
// Directed and random checks for mod7: residues, latency, pause, input latching, reset abort.
module tb_mod7;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [2:0]  configure;
  logic [31:0] serial_in;
  logic [2:0]  out;
  logic        cnt_out;
  logic        led;

  int          n_cmp;
  int          n_bad;
  logic [2:0]  last_out;

  mod7 dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .configure (configure),
    .serial_in (serial_in),
    .out       (out),
    .cnt_out   (cnt_out),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cfg;
    logic [31:0] val;
    logic [2:0]  exp;
  } vec_t;

  function automatic int n_of(input logic [2:0] cfg);
    int tbl [8] = '{32, 4, 5, 6, 8, 12, 16, 24};
    return tbl[cfg];
  endfunction

  function automatic logic exp_led(input logic [2:0] res);
`ifdef MOD7_LED_EN
    return (res == 3'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; inputs are scrambled during RUN to show they are ignored
  task automatic run_conv(input logic [2:0] cfg, input logic [31:0] val, input logic [2:0] exp,
                          input int pause_at, input int pause_len, input string tag);
    int n;
    int edges;
    int lat;
    n   = n_of(cfg);
    lat = 0;
    configure = cfg;
    serial_in = val;
    enable    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " strobe_low_after_capture"}, 32'(cnt_out), 32'd0);
    edges = 0;
    for (int c = 1; c <= n + pause_len + 4; c++) begin
      if (c == pause_at) begin
        enable = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          serial_in = $urandom;
          @(posedge clk);
          @(negedge clk);
          edges++;
          check({tag, " frozen_strobe"}, 32'(cnt_out), 32'd0);
          check({tag, " frozen_out"}, 32'(out), 32'(last_out));
        end
        enable = 1'b1;
      end
      serial_in = $urandom;
      configure = 3'($urandom);
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (cnt_out) begin
        lat = edges;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(n + ((pause_at > 0) ? pause_len : 0)));
    check({tag, " out"}, 32'(out), 32'(exp));
    check({tag, " led"}, 32'(led), 32'(exp_led(exp)));
    last_out = exp;
  endtask

  initial begin
    vec_t vecs [14];
    int   strobes;
    n_cmp     = 0;
    n_bad     = 0;
    last_out  = 3'd0;
    reset     = 1'b0;
    enable    = 1'b0;
    configure = 3'b000;
    serial_in = 32'd0;

    vecs[0]  = '{3'b000, 32'd100,        3'd2};
    vecs[1]  = '{3'b001, 32'h0000_001E,  3'd0};
    vecs[2]  = '{3'b011, 32'd46,         3'd4};
    vecs[3]  = '{3'b010, 32'd30,         3'd2};
    vecs[4]  = '{3'b000, 32'hFFFF_FFFF,  3'd3};
    vecs[5]  = '{3'b001, 32'd0,          3'd0};
    vecs[6]  = '{3'b001, 32'h0000_000F,  3'd1};
    vecs[7]  = '{3'b100, 32'h0000_00FF,  3'd3};
    vecs[8]  = '{3'b101, 32'h0000_0FFF,  3'd0};
    vecs[9]  = '{3'b110, 32'h0000_FFFF,  3'd1};
    vecs[10] = '{3'b111, 32'h00FF_FFFF,  3'd0};
    vecs[11] = '{3'b111, 32'd1000000,    3'd1};
    vecs[12] = '{3'b010, 32'hFFFF_FFE3,  3'd3};
    vecs[13] = '{3'b100, 32'h1234_5678,  3'd1};

    #1;
    check("reset out", 32'(out), 32'd0);
    check("reset cnt_out", 32'(cnt_out), 32'd0);
    check("reset led", 32'(led), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_conv(vecs[i].cfg, vecs[i].val, vecs[i].exp, 0, 0, $sformatf("vec%0d", i));

    // Five-cycle pause mid-RUN on a nonzero result, previous out is held while frozen
    run_conv(3'b000, 32'd100, 3'd2, 10, 5, "pause32");
    run_conv(3'b100, 32'd200, 3'd4, 3, 5, "pause8");

    // Reset mid-conversion: outputs clear at once and no strobe follows
    configure = 3'b000;
    serial_in = 32'hFFFF_FFFF;
    enable    = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    check("midrun_reset out", 32'(out), 32'd0);
    check("midrun_reset cnt_out", 32'(cnt_out), 32'd0);
    check("midrun_reset led", 32'(led), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    strobes = 0;
    repeat (40) begin
      @(negedge clk);
      if (cnt_out) strobes++;
    end
    check("post_reset strobes", 32'(strobes), 32'd0);
    check("post_reset out", 32'(out), 32'd0);
    last_out = 3'd0;
    run_conv(3'b001, 32'd13, 3'd6, 0, 0, "first_after_reset");

    // Random operands across all widths, back to back
    for (int r = 0; r < 1000; r++) begin
      logic [2:0]  cfg;
      logic [31:0] val;
      logic [63:0] mask;
      cfg  = 3'($urandom);
      val  = $urandom;
      mask = (64'd1 << n_of(cfg)) - 64'd1;
      run_conv(cfg, val, 3'((({32'd0, val} & mask) % 64'd7)), 0, 0, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod7.md
MOD7 -- requirements
Module: mod7

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port enable, input, 1 bit: high lets conversions start and advance; low freezes all state.
REQ-005 Port configure, input, 3 bits: selects the operand width N.
REQ-006 Port serial_in, input, 32 bits: unsigned operand; only bits [N-1:0] are used.
REQ-007 Port out, output, 3 bits: registered residue of the operand mod 7, range 0..6.
REQ-008 Port cnt_out, output, 1 bit: one-cycle completion strobe.
REQ-009 Port led, output, 1 bit: registered divisible-by-7 indicator.

Function
REQ-010 configure SHALL map to N as follows: 000=32, 001=4, 010=5, 011=6, 100=8, 101=12, 110=16, 111=24.
REQ-011 States SHALL be IDLE and RUN; no other states; any illegal encoding recovers to IDLE.
REQ-012 In IDLE with enable=1, a clock edge SHALL do all of the following:
- capture serial_in[N-1:0] into an internal shift register;
- latch N into a bit counter;
- clear the accumulator acc;
- enter RUN.
REQ-013 In RUN with enable=1, each edge SHALL consume the MSB of the captured operand: acc <= (2*acc + bit) mod 7.
REQ-014 acc SHALL stay 3 bits wide and never hold 7; the reduction is combinational (compare/subtract), not a divider.
REQ-015 On the edge consuming bit 0, the block SHALL do all of the following:
- load the final acc into out;
- assert cnt_out for exactly the following cycle;
- return to IDLE.
REQ-016 Latency: out and cnt_out SHALL update exactly N edges after the capture edge; steady-state period with enable held high is N+1 cycles.
REQ-017 Changes to serial_in or configure during RUN SHALL be ignored until the next capture.
REQ-018 enable=0 mid-RUN SHALL freeze counter, shift register, acc and out; cnt_out SHALL be 0 while frozen; processing resumes when enable returns high.
REQ-019 out SHALL hold its last result between completions; cnt_out SHALL be 0 except on completion cycles.
REQ-020 Boundary values: operand 0 SHALL yield 0; operand 2^N-1 SHALL yield (2^N-1) mod 7, e.g. 3 for N=32.

Reset
REQ-021 reset=0 SHALL immediately force the following, regardless of clk:
- out=0, cnt_out=0, led=0;
- acc=0, bit counter=0, shift register=0;
- state=IDLE.
REQ-022 Reset asserted mid-RUN SHALL abort the conversion; no cnt_out strobe SHALL follow.
REQ-023 After reset release, the first capture SHALL occur on the first clock edge with enable=1.

Configuration
REQ-024 Macro MOD7_LED_EN defined: led SHALL be registered high exactly when a completed result equals 0, updated on the same edge as out.
REQ-025 Macro MOD7_LED_EN undefined: led SHALL be tied to constant 0 and no led logic SHALL be synthesized.

Verification
REQ-026 Reset: assert reset=0 mid-RUN -> out=0, cnt_out=0, led=0 at once; no strobe follows after release.
REQ-027 Width 32: configure=000, serial_in=100, enable=1 -> out=2 after 32 edges, cnt_out high one cycle, led=0.
REQ-028 Width 4: configure=001, serial_in=0x0000001E -> only bits 1110 (14) used -> out=0, led=1 (MOD7_LED_EN defined), after 4 edges.
REQ-029 Other widths:
- configure=011, serial_in=46 -> out=4;
- configure=010, serial_in=30 -> out=2;
- configure=000, serial_in=0xFFFFFFFF -> out=3.
REQ-030 Pause and latch:
- enable=0 for 5 cycles mid-RUN -> completion delayed by exactly 5 cycles, same residue;
- serial_in changed during RUN -> result reflects the captured value.
REQ-031 Random: 1000 random operands over all configure codes -> out equals operand[N-1:0] mod 7 every time, and cnt_out pulses once per N+1 cycles.
